// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg -- shared definitions for the 8-way round-robin arbiter.
//
// Contents:
//   N_REQ        number of requesters (one-hot grant width)
//   PTR_W        width of the round-robin pointer (wraps modulo 8)
//   CNT_W        width of the optional hold counter
//   HOLD_MAX_DEF default forced-release limit for the hold counter
//   arb_state_t  FSM state enum (IDLE, BUSY)
//   onehot_to_idx  helper converting a one-hot vector to its bit index
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ        = 8;
  localparam int PTR_W        = 3;
  localparam int CNT_W        = 4;
  localparam int HOLD_MAX_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // OR-reduction encoder; only meaningful for a vector with at most one bit
  // set, which is all the arbiter ever hands it.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | PTR_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- combinational round-robin selector.
//
// Picks the lowest-indexed set bit of req at or above ptr, wrapping from the
// top index back to 0, and returns it as a one-hot vector (all-zero when no
// request is present).
//
// Ports:
//   req   [N-1:0]      request lines, bit i = requester i
//   ptr   [PTR_W-1:0]  index with highest priority this round
//   pick  [N-1:0]      one-hot selection, zero if req is zero
// ---------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = N_REQ
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Walk the requesters starting at ptr; the PTR_W-bit sum wraps naturally
  // modulo 8, so the scan order is ptr, ptr+1, ..., 7, 0, ..., ptr-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8 -- 8-requester round-robin arbiter with hold-until-release.
//
// In IDLE the arbiter picks the next requester at or after the pointer and
// registers a one-hot grant. In BUSY the grant is frozen until the grantee
// signals done or drops its request; release always passes through one IDLE
// cycle, and the pointer then moves just past the released requester.
//
// Optional feature (macro ARB_TIMEOUT_EN): a 4-bit hold counter forces a
// release after HOLD_MAX BUSY cycles and pulses timeout for that release.
// Without the macro the counter does not exist and timeout is tied low.
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low reset
//   req      [N-1:0] request lines
//   done     grantee finished (looked at only in BUSY)
//   grant    [N-1:0] registered one-hot grant, zero outside BUSY
//   valid    high exactly when grant is non-zero
//   timeout  one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic         timeout
);

  // The pointer, encoder and downstream 8-to-3 encoder all assume exactly
  // eight requesters, and the hold limit must fit the 4-bit counter.
  if (N != N_REQ) begin : g_bad_n
    $error("rr_arbiter8 supports only N = 8");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold
    $error("rr_arbiter8 HOLD_MAX must be in 1..15");
  end

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic [N-1:0]     pick;
  logic             normal_release;
  logic             hold_expired;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  // Grantee is finished either explicitly or by withdrawing its request.
  assign normal_release = done || !req[gidx];

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // hold_cnt counts completed BUSY cycles, so reaching HOLD_LAST means the
  // grant has now been visible for HOLD_MAX cycles.
  assign hold_expired = (hold_cnt == HOLD_LAST);
  assign timeout      = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Single FSM block: state, pointer, latched grant index and the registered
  // outputs all change together so grant/valid never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      valid <= 1'b0;
      ptr   <= '0;
      gidx  <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            valid <= 1'b1;
            gidx  <= onehot_to_idx(pick);
            state <= BUSY;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (normal_release || hold_expired) begin
            grant <= '0;
            valid <= 1'b0;
            ptr   <= gidx + 1'b1;
            state <= IDLE;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= !normal_release;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8 -- self-checking bench for rr_arbiter8.
//
// A behavioural model tracks who should hold the grant; a negedge process
// compares the DUT against it every cycle, and directed steps pin specific
// literal grant values. Timeout behaviour is exercised when the bench is
// built with ARB_TIMEOUT_EN, otherwise an indefinite hold is checked.
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

  localparam int HOLD = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       valid;
  logic       timeout;

  int vectors    = 0;
  int miscompares = 0;

  rr_arbiter8 #(.N(8), .HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who holds the grant, where the next search starts, how long the
  // grant has been visible, and whether the last edge was a forced release.
  bit armed  = 1'b0;
  bit m_busy = 1'b0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_held = 0;
  bit m_to   = 1'b0;

  always @(posedge clk) begin
    armed = 1'b1;
    m_to  = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_idx  = 0;
      m_ptr  = 0;
      m_held = 0;
    end else if (!m_busy) begin
      if (req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (!m_busy && req[(m_ptr + k) % 8]) begin
            m_idx  = (m_ptr + k) % 8;
            m_busy = 1'b1;
            m_held = 1;
          end
        end
      end
    end else begin
      if (done || !req[m_idx]) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % 8;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_held >= HOLD) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % 8;
        m_to   = 1'b1;
      end
`endif
      else begin
        m_held = m_held + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [7:0] exp_g;
    if (armed) begin
      exp_g = m_busy ? (8'b1 << m_idx) : 8'b0;
      vectors++;
      if (grant !== exp_g) begin
        miscompares++;
        $display("[TB] FAIL model_grant t=%0t: got %b expected %b", $time, grant, exp_g);
      end
      vectors++;
      if (valid !== m_busy) begin
        miscompares++;
        $display("[TB] FAIL model_valid t=%0t: got %b expected %b", $time, valid, m_busy);
      end
      vectors++;
      if (timeout !== m_to) begin
        miscompares++;
        $display("[TB] FAIL model_timeout t=%0t: got %b expected %b", $time, timeout, m_to);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic d, input int cycles);
    rst_n = r;
    req   = rq;
    done  = d;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // Reset state
    applyStimulus(1'b0, 8'h00, 1'b0, 2);
    checkOutput("reset_grant", grant, 8'h00);
    checkOutput("reset_valid", {7'b0, valid}, 8'h00);
    checkOutput("reset_timeout", {7'b0, timeout}, 8'h00);

    // Idle with no requests stays idle
    applyStimulus(1'b1, 8'h00, 1'b0, 2);
    checkOutput("idle_noreq", grant, 8'h00);

    // First grant favours index 0, one-cycle latency
    applyStimulus(1'b1, 8'b0000_0101, 1'b0, 1);
    checkOutput("first_grant", grant, 8'b0000_0001);
    checkOutput("first_valid", {7'b0, valid}, 8'h01);

    // done pulse: one idle cycle, then ptr=1 skips bit 0
    applyStimulus(1'b1, 8'b0000_0101, 1'b1, 1);
    checkOutput("done_release", grant, 8'h00);
    applyStimulus(1'b1, 8'b0000_0101, 1'b0, 1);
    checkOutput("after_done", grant, 8'b0000_0100);

    // Grantee drops req: release, ptr=3, wrap to bit 0
    applyStimulus(1'b1, 8'b0000_0001, 1'b0, 1);
    checkOutput("drop_release", grant, 8'h00);
    applyStimulus(1'b1, 8'b0000_0001, 1'b0, 1);
    checkOutput("wrap_from3", grant, 8'b0000_0001);
    applyStimulus(1'b1, 8'b0000_0001, 1'b1, 1);
    applyStimulus(1'b1, 8'b0000_0000, 1'b0, 1);

    // Steer ptr to 7 through a grant on bit 6, then wrap test
    applyStimulus(1'b1, 8'b0100_0000, 1'b0, 1);
    checkOutput("grant_bit6", grant, 8'b0100_0000);
    applyStimulus(1'b1, 8'b0000_0000, 1'b0, 1);
    applyStimulus(1'b1, 8'b1000_0001, 1'b0, 1);
    checkOutput("ptr7_grant", grant, 8'b1000_0000);
    applyStimulus(1'b1, 8'b1000_0001, 1'b1, 1);
    checkOutput("ptr7_release", grant, 8'h00);
    applyStimulus(1'b1, 8'b1000_0001, 1'b0, 1);
    checkOutput("ptr0_wrap", grant, 8'b0000_0001);

    // Grant held while other req bits change
    applyStimulus(1'b1, 8'b1111_1111, 1'b0, 3);
    checkOutput("hold_other_req", grant, 8'b0000_0001);

    // Grant bit 4, drop it, ptr must be 5
    applyStimulus(1'b1, 8'b1111_1111, 1'b1, 1);
    applyStimulus(1'b1, 8'b0001_0000, 1'b0, 1);
    checkOutput("grant_bit4", grant, 8'b0001_0000);
    applyStimulus(1'b1, 8'b0000_0000, 1'b0, 1);
    checkOutput("drop_bit4", grant, 8'h00);
    applyStimulus(1'b1, 8'b0010_0001, 1'b0, 1);
    checkOutput("ptr5_pick", grant, 8'b0010_0000);

    // done and new requests together: release first, then re-arbitrate
    applyStimulus(1'b1, 8'b1111_1111, 1'b1, 1);
    checkOutput("done_with_req", grant, 8'h00);
    applyStimulus(1'b1, 8'b1111_1111, 1'b0, 1);
    checkOutput("rearb_ptr6", grant, 8'b0100_0000);

    // Reset mid-BUSY clears at that edge; first grant afterwards is bit 0
    applyStimulus(1'b0, 8'b1111_1111, 1'b0, 1);
    checkOutput("midbusy_rst_grant", grant, 8'h00);
    checkOutput("midbusy_rst_valid", {7'b0, valid}, 8'h00);
    applyStimulus(1'b1, 8'b1111_1111, 1'b0, 1);
    checkOutput("post_rst_grant", grant, 8'b0000_0001);

    // done in IDLE is ignored
    applyStimulus(1'b1, 8'b0000_0000, 1'b0, 1);
    applyStimulus(1'b1, 8'b0000_0010, 1'b1, 1);
    checkOutput("done_in_idle", grant, 8'b0000_0010);
    applyStimulus(1'b1, 8'b0000_0000, 1'b0, 2);

    // Long hold: forced release with the timeout feature, indefinite without
    applyStimulus(1'b1, 8'b0000_1000, 1'b0, 1);
    checkOutput("long_first", grant, 8'b0000_1000);
    applyStimulus(1'b1, 8'b0000_1000, 1'b0, HOLD - 1);
    checkOutput("long_last_held", grant, 8'b0000_1000);
`ifdef ARB_TIMEOUT_EN
    applyStimulus(1'b1, 8'b0000_1000, 1'b0, 1);
    checkOutput("timeout_pulse", {7'b0, timeout}, 8'h01);
    checkOutput("timeout_grant", grant, 8'h00);
    applyStimulus(1'b1, 8'b0000_1000, 1'b0, 1);
    checkOutput("timeout_clear", {7'b0, timeout}, 8'h00);
    checkOutput("timeout_regrant", grant, 8'b0000_1000);
`else
    applyStimulus(1'b1, 8'b0000_1000, 1'b0, 20);
    checkOutput("no_timeout_hold", grant, 8'b0000_1000);
    checkOutput("no_timeout_flag", {7'b0, timeout}, 8'h00);
`endif
    applyStimulus(1'b1, 8'b0000_0000, 1'b0, 2);

    // Mixed traffic checked only by the model
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
      done = ($urandom_range(0, 4) == 0);
      @(posedge clk);
      #1;
    end

    applyStimulus(1'b1, 8'h00, 1'b0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: N, 8, number of requesters; the one-hot grant width feeding the downstream 8-to-3 encoder.
REQ-002 Parameter: HOLD_MAX, 15, maximum cycles a grant is held before forced release (used only when ARB_TIMEOUT_EN is defined).
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: req  input  N  request lines, bit i = requester i.
REQ-006 Port: done  input  1  current grantee finished, sampled only in BUSY.
REQ-007 Port: grant  output  N  registered grant, one-hot in BUSY, all-zero otherwise.
REQ-008 Port: valid  output  1  high exactly when grant is non-zero.
REQ-009 Port: timeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-010 The FSM SHALL have two states: IDLE and BUSY.
REQ-011 In IDLE with req = 0, the block SHALL stay in IDLE with grant = 0.
REQ-012 In IDLE with req != 0, the block SHALL select the lowest-indexed set bit at or above pointer ptr, wrapping from 7 to 0, and register it as grant; grant appears on the edge after req is sampled (1-cycle latency), then the block enters BUSY.
REQ-013 In BUSY, grant SHALL be held constant regardless of changes to other req bits.
REQ-014 In BUSY, done = 1 or deassertion of the grantee's req bit SHALL cause release: grant = 0 on the next edge, state goes to IDLE, and ptr is set to (granted index + 1) mod 8.
REQ-015 At least one IDLE cycle SHALL occur between consecutive grants, so grant never changes directly from one one-hot value to another.
REQ-016 When done and new requests occur in the same cycle, the block SHALL release first and re-arbitrate in the following IDLE cycle.
REQ-017 grant SHALL never have more than one bit set.
REQ-018 ptr SHALL be 3 bits wide and wrap modulo 8.

Reset
REQ-019 While rst_n = 0 at a clock edge, the block SHALL set state = IDLE, grant = 0, valid = 0, ptr = 0, timeout = 0 and the hold counter = 0.
REQ-020 Reset asserted mid-BUSY SHALL clear grant at that edge, regardless of done or req.
REQ-021 The first arbitration after reset SHALL favour index 0.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: a 4-bit hold counter SHALL clear on entry to BUSY and increment each BUSY cycle; when it reaches HOLD_MAX without release, the block SHALL force release per REQ-014 and pulse timeout high for that release cycle.
REQ-023 Macro ARB_TIMEOUT_EN undefined: the counter SHALL be absent, timeout SHALL be constant 0, and grants SHALL be held indefinitely until release.

Structure
REQ-024 Shared package arb_pkg SHALL contain the state enum (IDLE, BUSY), N, the pointer width (3) and the HOLD_MAX default.
REQ-025 The combinational round-robin selection (inputs req and ptr, output one-hot pick) SHALL be the sub-module rr_pick; rr_arbiter8 SHALL contain the FSM, pointer, counter and output registers.

Verification
REQ-026 Reset, then req = 8'b0000_0101 held -> grant = 8'b0000_0001 one cycle later, valid = 1.
REQ-027 After REQ-026, done pulsed -> grant = 0 for one cycle, then grant = 8'b0000_0100 (ptr = 1 skips bit 0).
REQ-028 ptr = 7 with req = 8'b1000_0001 -> grant = 8'b1000_0000; after release, with req unchanged -> grant = 8'b0000_0001 (wrap).
REQ-029 In BUSY with grant = 8'b0001_0000, the grantee drops req bit 4 -> grant = 0 next edge, ptr = 5.
REQ-030 ARB_TIMEOUT_EN defined, req = 8'b0000_1000, done never asserted -> after 15 BUSY cycles, timeout = 1 for one cycle and grant = 0.
REQ-031 rst_n = 0 asserted mid-BUSY -> grant = 0 and valid = 0 at that edge; after reset, req = 8'b1111_1111 -> grant = 8'b0000_0001.
